// File: rtl/clk_lock_pkg.sv
// clk_lock_pkg: FSM state type and counter-width helper for the lock sequencer
package clk_lock_pkg;

    typedef enum logic [1:0] {RESET, WAIT_LOCK, STABLE, RUN} state_t;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a > b ? a : b;
        m = m > c ? m : c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/cdc_bit_sync.sv
// cdc_bit_sync: two-flop synchroniser over a vector of independent bits
module cdc_bit_sync #(
    parameter int W = 1
) (
    input  logic         BUS_CLK,
    input  logic         BUS_RST,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge BUS_CLK)
        if (BUS_RST) {q, meta} <= '0;
        else         {q, meta} <= {meta, d};

endmodule

// File: rtl/clk_lock_sequencer.sv
// clk_lock_sequencer: cascade-ordered reset sequencing of clock managers with lock supervision
module clk_lock_sequencer
    import clk_lock_pkg::*;
#(
    parameter int N_STAGE         = 2,
    parameter int FIRST_STAGE_RST = 0,
    parameter int RST_HOLD        = 4,
    parameter int STABLE_CNT      = 16,
    parameter int LOCK_TIMEOUT    = 65535,
    parameter int CNT_W           = 8
) (
    input  logic               BUS_CLK,
    input  logic               BUS_RST,
    input  logic [N_STAGE-1:0] LOCKED_IN,
    input  logic               CLR_CNT,
    input  logic               FORCE_RESTART,
    output logic [N_STAGE-1:0] DCM_RST,
    output logic [N_STAGE-1:0] STAGE_READY,
    output logic               ALL_LOCKED,
    output logic [CNT_W-1:0]   UNLOCK_CNT,
    output logic               TIMEOUT_ERR
);

    localparam int TW = cnt_width(RST_HOLD, STABLE_CNT, LOCK_TIMEOUT);
    localparam int IW = N_STAGE > 1 ? $clog2(N_STAGE) : 1;

    logic [N_STAGE-1:0] lk, loss, keep;
    logic [IW-1:0]      loss_idx, cur;
    logic [TW-1:0]      cnt;
    logic               lk_cur, ev_unlock, ev_to;
    state_t             state;

    cdc_bit_sync #(.W(N_STAGE)) u_sync (
        .BUS_CLK(BUS_CLK),
        .BUS_RST(BUS_RST),
        .d      (LOCKED_IN),
        .q      (lk)
    );

    function automatic logic ctrl(input int k);
        return (k != 0) || (FIRST_STAGE_RST != 0);
    endfunction

    // Reset pattern for a given (state, stage): current stage in RESET plus every downstream stage.
    function automatic logic [N_STAGE-1:0] rst_vec(input state_t st, input logic [IW-1:0] c);
        logic [N_STAGE-1:0] v;
        v = '0;
        for (int k = 0; k < N_STAGE; k++)
            v[k] = ctrl(k) && st != RUN && (k > int'(c) || (k == int'(c) && st == RESET));
        return v;
    endfunction

    always_comb begin
        loss     = STAGE_READY & ~lk;
        loss_idx = '0;
        keep     = '0;
        for (int k = N_STAGE - 1; k >= 0; k--)
            if (loss[k]) loss_idx = IW'(k);
        for (int k = 0; k < N_STAGE; k++)
            keep[k] = k < int'(loss_idx);
    end

    assign lk_cur    = lk[cur];
    assign ev_unlock = |loss && !FORCE_RESTART;
    assign ev_to     = state == WAIT_LOCK && !lk_cur && cnt == TW'(LOCK_TIMEOUT - 1) && !FORCE_RESTART && !(|loss);

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST || FORCE_RESTART) begin
            state       <= ctrl(0) ? RESET : WAIT_LOCK;
            cur         <= '0;
            cnt         <= '0;
            STAGE_READY <= '0;
            ALL_LOCKED  <= 1'b0;
            DCM_RST     <= rst_vec(RESET, '0);
        end else if (|loss) begin
            state       <= ctrl(int'(loss_idx)) ? RESET : WAIT_LOCK;
            cur         <= loss_idx;
            cnt         <= '0;
            STAGE_READY <= STAGE_READY & keep;
            ALL_LOCKED  <= 1'b0;
            DCM_RST     <= rst_vec(RESET, loss_idx);
        end else begin
            case (state)
                RESET:
                    if (cnt == TW'(RST_HOLD - 1)) begin
                        state   <= WAIT_LOCK;
                        cnt     <= '0;
                        DCM_RST <= rst_vec(WAIT_LOCK, cur);
                    end else cnt <= cnt + 1'b1;
                WAIT_LOCK:
                    if (lk_cur) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (ev_to) begin
                        cnt <= '0;
                        if (ctrl(int'(cur))) begin
                            state   <= RESET;
                            DCM_RST <= rst_vec(RESET, cur);
                        end
                    end else cnt <= cnt + 1'b1;
                STABLE:
                    if (!lk_cur) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == TW'(STABLE_CNT - 1)) begin
                        STAGE_READY[cur] <= 1'b1;
                        cnt              <= '0;
                        if (int'(cur) == N_STAGE - 1) begin
                            state   <= RUN;
                            DCM_RST <= '0;
                        end else begin
                            state   <= RESET;
                            cur     <= cur + 1'b1;
                            DCM_RST <= rst_vec(RESET, IW'(cur + 1'b1));
                        end
                    end else cnt <= cnt + 1'b1;
                RUN:
                    ALL_LOCKED <= 1'b1;
            endcase
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            UNLOCK_CNT  <= '0;
            TIMEOUT_ERR <= 1'b0;
        end else begin
            UNLOCK_CNT  <= CLR_CNT ? CNT_W'(ev_unlock) : UNLOCK_CNT + CNT_W'(ev_unlock && !(&UNLOCK_CNT));
            TIMEOUT_ERR <= ev_to || (TIMEOUT_ERR && !CLR_CNT);
        end
    end

endmodule

// File: tb/tb_clk_lock_sequencer.sv
// tb_clk_lock_sequencer: table-driven bring-up/loss vectors plus directed timeout, glitch, saturation and restart sequences
module tb_clk_lock_sequencer;

    logic       BUS_CLK = 1'b0;
    logic       BUS_RST = 1'b1;
    logic [1:0] LOCKED_IN = 2'b00;
    logic       CLR_CNT = 1'b0;
    logic       FORCE_RESTART = 1'b0;
    logic [1:0] DCM_RST, STAGE_READY, UNLOCK_CNT;
    logic       ALL_LOCKED, TIMEOUT_ERR;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [1:0] lock;
        int         n;
        logic [1:0] dcm;
        logic [1:0] rdy;
        logic       all;
        logic [1:0] cnt;
        logic       to;
    } vec_t;

    vec_t tbl[18];

    clk_lock_sequencer #(
        .N_STAGE(2), .FIRST_STAGE_RST(0), .RST_HOLD(4),
        .STABLE_CNT(16), .LOCK_TIMEOUT(100), .CNT_W(2)
    ) dut (
        .BUS_CLK      (BUS_CLK),
        .BUS_RST      (BUS_RST),
        .LOCKED_IN    (LOCKED_IN),
        .CLR_CNT      (CLR_CNT),
        .FORCE_RESTART(FORCE_RESTART),
        .DCM_RST      (DCM_RST),
        .STAGE_READY  (STAGE_READY),
        .ALL_LOCKED   (ALL_LOCKED),
        .UNLOCK_CNT   (UNLOCK_CNT),
        .TIMEOUT_ERR  (TIMEOUT_ERR)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    function automatic vec_t mk(input logic [1:0] lock, input int n, input logic [1:0] dcm,
                                input logic [1:0] rdy, input logic all, input logic [1:0] cnt, input logic to);
        vec_t v;
        v.lock = lock; v.n = n; v.dcm = dcm; v.rdy = rdy; v.all = all; v.cnt = cnt; v.to = to;
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge BUS_CLK);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_sig(input int sel, input logic val, input string name);
        logic ok, s;
        ok = 1'b0;
        tests++;
        for (int k = 0; k < 300 && !ok; k++) begin
            s = sel == 0 ? STAGE_READY[0] : sel == 1 ? STAGE_READY[1] : sel == 2 ? ALL_LOCKED : DCM_RST[1];
            if (s === val) ok = 1'b1;
            else tick(1);
        end
        if (!ok) begin
            fails++;
            $display("FAIL %s: still %0b after 300 cycles, wanted %0b", name, s, val);
        end
    endtask

    task automatic do_reset(input logic [1:0] lock);
        BUS_RST = 1'b1;
        LOCKED_IN = lock;
        tick(3);
        BUS_RST = 1'b0;
    endtask

    initial begin
        // Nominal bring-up, then run-time loss of stage 0 and resequencing.
        tbl = '{
            mk(2'b00,  5, 2'b10, 2'b00, 1'b0, 2'd0, 1'b0),
            mk(2'b01, 18, 2'b10, 2'b00, 1'b0, 2'd0, 1'b0),
            mk(2'b01,  1, 2'b10, 2'b01, 1'b0, 2'd0, 1'b0),
            mk(2'b01,  3, 2'b10, 2'b01, 1'b0, 2'd0, 1'b0),
            mk(2'b01,  1, 2'b00, 2'b01, 1'b0, 2'd0, 1'b0),
            mk(2'b01, 10, 2'b00, 2'b01, 1'b0, 2'd0, 1'b0),
            mk(2'b11, 18, 2'b00, 2'b01, 1'b0, 2'd0, 1'b0),
            mk(2'b11,  1, 2'b00, 2'b11, 1'b0, 2'd0, 1'b0),
            mk(2'b11,  1, 2'b00, 2'b11, 1'b1, 2'd0, 1'b0),
            mk(2'b10,  2, 2'b00, 2'b11, 1'b1, 2'd0, 1'b0),
            mk(2'b10,  1, 2'b10, 2'b00, 1'b0, 2'd1, 1'b0),
            mk(2'b10,  2, 2'b10, 2'b00, 1'b0, 2'd1, 1'b0),
            mk(2'b11, 18, 2'b10, 2'b00, 1'b0, 2'd1, 1'b0),
            mk(2'b11,  1, 2'b10, 2'b01, 1'b0, 2'd1, 1'b0),
            mk(2'b11,  4, 2'b00, 2'b01, 1'b0, 2'd1, 1'b0),
            mk(2'b11, 16, 2'b00, 2'b01, 1'b0, 2'd1, 1'b0),
            mk(2'b11,  1, 2'b00, 2'b11, 1'b0, 2'd1, 1'b0),
            mk(2'b11,  1, 2'b00, 2'b11, 1'b1, 2'd1, 1'b0)
        };

        tick(3);
        check("rst_dcm", 32'(DCM_RST), 32'(2'b10));
        check("rst_outs", 32'({STAGE_READY, ALL_LOCKED, UNLOCK_CNT, TIMEOUT_ERR}), 32'd0);
        BUS_RST = 1'b0;

        for (int i = 0; i < 18; i++) begin
            LOCKED_IN = tbl[i].lock;
            tick(tbl[i].n);
            check($sformatf("vec%0d {dcm,rdy,all,cnt,to}", i),
                  32'({DCM_RST, STAGE_READY, ALL_LOCKED, UNLOCK_CNT, TIMEOUT_ERR}),
                  32'({tbl[i].dcm, tbl[i].rdy, tbl[i].all, tbl[i].cnt, tbl[i].to}));
        end

        // Glitch on stage 1 lock at stable count 10 restarts the stability count.
        do_reset(2'b01);
        wait_sig(0, 1'b1, "glitch_rdy0");
        wait_sig(3, 1'b0, "glitch_dcm1_fall");
        LOCKED_IN = 2'b11;
        tick(13);
        LOCKED_IN = 2'b01;
        tick(2);
        LOCKED_IN = 2'b11;
        tick(4);
        check("glitch_nominal_time", 32'(STAGE_READY), 32'(2'b01));
        tick(14);
        check("glitch_before_ready", 32'(STAGE_READY), 32'(2'b01));
        tick(1);
        check("glitch_ready", 32'(STAGE_READY), 32'(2'b11));
        check("glitch_cnt", 32'(UNLOCK_CNT), 32'd0);
        wait_sig(2, 1'b1, "glitch_all");

        // Five stage-1 losses saturate the 2-bit counter.
        for (int i = 0; i < 5; i++) begin
            LOCKED_IN = 2'b01;
            tick(4);
            check($sformatf("sat_loss%0d", i), 32'(UNLOCK_CNT), i < 3 ? i + 1 : 3);
            LOCKED_IN = 2'b11;
            wait_sig(2, 1'b1, "sat_relock");
        end
        LOCKED_IN = 2'b01;
        tick(2);
        CLR_CNT = 1'b1;
        tick(1);
        CLR_CNT = 1'b0;
        check("clr_with_loss", 32'(UNLOCK_CNT), 32'd1);
        LOCKED_IN = 2'b11;
        wait_sig(2, 1'b1, "clr_relock");

        // Restart with stage 1 unlocked, then run into the lock timeout.
        LOCKED_IN = 2'b01;
        FORCE_RESTART = 1'b1;
        tick(1);
        FORCE_RESTART = 1'b0;
        check("force_outs", 32'({DCM_RST, STAGE_READY, ALL_LOCKED, UNLOCK_CNT, TIMEOUT_ERR}),
              32'({2'b10, 2'b00, 1'b0, 2'd1, 1'b0}));
        wait_sig(0, 1'b1, "to_rdy0");
        wait_sig(3, 1'b0, "to_dcm1_fall");
        tick(99);
        check("to_before", 32'({TIMEOUT_ERR, DCM_RST}), 32'({1'b0, 2'b00}));
        tick(1);
        check("to_hit", 32'({TIMEOUT_ERR, DCM_RST}), 32'({1'b1, 2'b10}));
        tick(3);
        check("to_rst_hold", 32'(DCM_RST), 32'(2'b10));
        tick(1);
        check("to_rst_release", 32'(DCM_RST), 32'(2'b00));
        LOCKED_IN = 2'b11;
        wait_sig(2, 1'b1, "to_all");
        check("to_sticky", 32'({TIMEOUT_ERR, UNLOCK_CNT}), 32'({1'b1, 2'd1}));

        FORCE_RESTART = 1'b1;
        tick(1);
        FORCE_RESTART = 1'b0;
        check("force_keep", 32'({DCM_RST, STAGE_READY, ALL_LOCKED, UNLOCK_CNT, TIMEOUT_ERR}),
              32'({2'b10, 2'b00, 1'b0, 2'd1, 1'b1}));
        wait_sig(2, 1'b1, "force_relock");
        CLR_CNT = 1'b1;
        tick(1);
        CLR_CNT = 1'b0;
        check("clr_plain", 32'({UNLOCK_CNT, TIMEOUT_ERR}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
